// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcode encoding, default latencies and issue FSM states.
// Used by both the E-stage issue controller and the multiply/divide unit itself.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MFHI  = 4'd1;
  localparam logic [3:0] OP_MFLO  = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_MULTU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_WAIT
  } mdu_state_e;

  // Ops that start a multi-cycle mult/div and occupy the MDU
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  // Any op that touches the MDU (HI/LO moves included); 9..15 count as none
  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op >= OP_MFHI) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Busy-window countdown: load on start, freeze on hold, decrement toward zero.
// done flags the last busy cycle that will actually advance.
module mdu_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hold && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1)) && !hold;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU initiator: decodes e_op, drives MDU ctrl/operands/start and stalls D/E
// while a mult/div is in flight. Optional busy cross-check under MDU_BUSY_CHECK_EN.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        Req,
  input  logic        mdu_busy,
  output logic [3:0]  mdu_ctrl,
  output logic [31:0] mdu_inA,
  output logic [31:0] mdu_inB,
  output logic        mdu_start,
  output logic        stall_e,
  output logic        busy_local,
  output logic        busy_mismatch
);

  mdu_state_e       state, state_nxt;
  logic             is_md, is_mdu, go;
  logic             cnt_load, cnt_hold, cnt_done;
  logic [CNT_W-1:0] cnt_load_val;

  assign is_md      = is_md_op(e_op);
  assign is_mdu     = is_mdu_op(e_op);
  assign busy_local = (state != IDLE);
  assign stall_e    = e_valid && is_mdu && busy_local;
  // Gating with reset keeps every output at 0 while reset is asserted
  assign go         = reset && e_valid && is_mdu && !stall_e && !Req;
  assign mdu_ctrl   = go ? e_op : OP_NONE;
  assign mdu_start  = go && is_md;
  assign mdu_inA    = reset ? e_rs : '0;
  assign mdu_inB    = reset ? e_rt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_hold     = 1'b1;
    case (state)
      IDLE: begin
        if (mdu_start) begin
          cnt_load = 1'b1;
          if ((e_op == OP_MULT) || (e_op == OP_MULTU)) begin
            cnt_load_val = CNT_W'(MULT_LAT);
            state_nxt    = MUL_WAIT;
          end else begin
            cnt_load_val = CNT_W'(DIV_LAT);
            state_nxt    = DIV_WAIT;
          end
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        // Req freezes the window exactly like the MDU's own status counter
        cnt_hold = Req;
        if (cnt_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  mdu_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .hold    (cnt_hold),
    .done    (cnt_done)
  );

`ifdef MDU_BUSY_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_mismatch <= 1'b0;
    end else if (mdu_busy != busy_local) begin
      busy_mismatch <= 1'b1;
    end
  end
`else
  logic unused_mdu_busy;
  assign unused_mdu_busy = mdu_busy;
  assign busy_mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural MDU model driven by the DUT.
// Honours MDU_BUSY_CHECK_EN for the expected busy_mismatch value.
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

`ifdef MDU_BUSY_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = '0;
  logic [31:0] e_rs = '0;
  logic [31:0] e_rt = '0;
  logic        Req = 1'b0;
  logic        mdu_busy;
  logic [3:0]  mdu_ctrl;
  logic [31:0] mdu_inA, mdu_inB;
  logic        mdu_start, stall_e, busy_local, busy_mismatch;

  always #5 clk = ~clk;

  mdu_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .e_valid      (e_valid),
    .e_op         (e_op),
    .e_rs         (e_rs),
    .e_rt         (e_rt),
    .Req          (Req),
    .mdu_busy     (mdu_busy),
    .mdu_ctrl     (mdu_ctrl),
    .mdu_inA      (mdu_inA),
    .mdu_inB      (mdu_inB),
    .mdu_start    (mdu_start),
    .stall_e      (stall_e),
    .busy_local   (busy_local),
    .busy_mismatch(busy_mismatch)
  );

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] cyc;
  } iss_t;

  iss_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MDU: results computed at start, busy counter frozen by Req
  logic [31:0] m_hi, m_lo;
  int          m_cnt;
  logic        force_busy = 1'b0;

  function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_MULT:  return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV:   return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      OP_DIVU:  return {a % b, a / b};
      default:  return 64'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt <= 0;
    end else begin
      if (mdu_start) begin
        m_cnt <= ((mdu_ctrl == OP_MULT) || (mdu_ctrl == OP_MULTU)) ? MULT_LAT_DEF : DIV_LAT_DEF;
        {m_hi, m_lo} <= mdu_calc(mdu_ctrl, mdu_inA, mdu_inB);
      end else if ((m_cnt != 0) && !Req) begin
        m_cnt <= m_cnt - 1;
      end
      if (mdu_ctrl == OP_MTHI) m_hi <= mdu_inA;
      if (mdu_ctrl == OP_MTLO) m_lo <= mdu_inA;
    end
  end

  assign mdu_busy = (m_cnt != 0) || force_busy;

  // Monitor: every issue seen at the MDU interface must match the next expected one
  always @(negedge clk) begin
    iss_t e;
    iss_t act;
    if (reset) begin
      if (mdu_start) begin
        tests++;
        if (stall_e) begin
          fails++;
          $display("FAIL start_while_stall cyc=%0d actual stall_e=1 required 0", cyc);
        end
      end
      if (mdu_ctrl != OP_NONE) begin
        tests++;
        act = {mdu_ctrl, mdu_start, mdu_inA, mdu_inB, 32'(cyc)};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_issue cyc=%0d actual ctrl=%0d required no issue", cyc, mdu_ctrl);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL issue actual ctrl=%0d start=%0b a=%h b=%h cyc=%0d required ctrl=%0d start=%0b a=%h b=%h cyc=%0d",
                     act.ctrl, act.start, act.a, act.b, act.cyc, e.ctrl, e.start, e.a, e.b, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    e_valid = v;
    e_op    = op;
    e_rs    = a;
    e_rt    = b;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int at);
    iss_t r;
    r = {op, ((op >= OP_MULT) && (op <= OP_DIVU)), a, b, 32'(at)};
    exp_q.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    int c;
    int stalls;
    int busy;

    // Reset: outputs all zero even with a mult presented
    drive(1'b1, OP_MULT, 32'd3, 32'hFFFF_FFFE);
    tick();
    tick();
    chk("reset_ctrl_flags", {24'd0, mdu_ctrl, mdu_start, stall_e, busy_local, busy_mismatch}, 32'd0);
    chk("reset_inA", mdu_inA, 32'd0);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    #2 reset = 1'b1;

    // mult 3 * -2 then mflo: five stall cycles, mflo issues six cycles after mult
    tick();
    c = cyc;
    drive(1'b1, OP_MULT, 32'd3, 32'hFFFF_FFFE);
    push(OP_MULT, 32'd3, 32'hFFFF_FFFE, c);
    tick();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    push(OP_MFLO, 32'd0, 32'd0, c + 6);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      if (stall_e) stalls++;
      tick();
    end
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    chk("mult_stall_cycles", stalls, 32'd5);
    chk("mult_lo", m_lo, 32'hFFFF_FFFA);
    chk("mult_hi", m_hi, 32'hFFFF_FFFF);

    // divu 100/7 with Req high three cycles mid-window: busy lasts 13 cycles
    c = cyc;
    drive(1'b1, OP_DIVU, 32'd100, 32'd7);
    push(OP_DIVU, 32'd100, 32'd7, c);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      Req = (i >= 2) && (i <= 4);
      if (i == 0) drive(1'b1, 4'd12, 32'd0, 32'd0);
      else if (i <= 5) drive(1'b1, OP_MFHI, 32'd0, 32'd0);
      else drive(1'b0, OP_NONE, 32'd0, 32'd0);
      #1;
      if (i == 0) chk("op12_no_stall", {31'd0, stall_e}, 32'd0);
      if (Req) chk("ctrl_during_req", {28'd0, mdu_ctrl}, 32'd0);
      if (busy_local) busy++;
    end
    Req = 1'b0;
    chk("divu_busy_cycles", busy, 32'd13);
    chk("divu_hi", m_hi, 32'd2);
    chk("divu_lo", m_lo, 32'd14);

    // mult with Req in the same cycle: no issue, no state change
    tick();
    drive(1'b1, OP_MULT, 32'd1, 32'd1);
    Req = 1'b1;
    #1;
    chk("req_blocks_start", {31'd0, mdu_start}, 32'd0);
    chk("req_blocks_ctrl", {28'd0, mdu_ctrl}, 32'd0);
    tick();
    Req = 1'b0;
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    #1;
    chk("req_keeps_idle", {31'd0, busy_local}, 32'd0);

    // mtlo, mult back-to-back; div behind the mult stalls exactly five cycles
    tick();
    c = cyc;
    drive(1'b1, OP_MTLO, 32'h1234, 32'd0);
    push(OP_MTLO, 32'h1234, 32'd0, c);
    tick();
    chk("mtlo_lo", m_lo, 32'h1234);
    drive(1'b1, OP_MULT, 32'd7, 32'd6);
    push(OP_MULT, 32'd7, 32'd6, c + 1);
    tick();
    drive(1'b1, OP_DIV, 32'd50, 32'd5);
    push(OP_DIV, 32'd50, 32'd5, c + 7);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      if (stall_e) stalls++;
      tick();
    end
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    chk("div_stall_cycles", stalls, 32'd5);
    repeat (10) tick();
    chk("div_lo", m_lo, 32'd10);
    chk("div_hi", m_hi, 32'd0);

    // Reset mid DIV_WAIT: stall drops at once, mult issues on first cycle after release
    c = cyc;
    drive(1'b1, OP_DIV, 32'd9, 32'd3);
    push(OP_DIV, 32'd9, 32'd3, c);
    tick();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    repeat (4) tick();
    #1;
    chk("stall_before_reset", {31'd0, stall_e}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("stall_in_reset", {31'd0, stall_e}, 32'd0);
    chk("busy_in_reset", {31'd0, busy_local}, 32'd0);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    drive(1'b1, OP_MULT, 32'd2, 32'd3);
    push(OP_MULT, 32'd2, 32'd3, cyc);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    repeat (6) tick();
    chk("post_reset_mult_lo", m_lo, 32'd6);

    // MDU busy one cycle ahead of the local copy
    chk("mismatch_clear_before", {31'd0, busy_mismatch}, 32'd0);
    force_busy = 1'b1;
    tick();
    force_busy = 1'b0;
    chk("mismatch_set", {31'd0, busy_mismatch}, {31'd0, EXP_MM});
    repeat (3) tick();
    chk("mismatch_sticky", {31'd0, busy_mismatch}, {31'd0, EXP_MM});
    reset = 1'b0;
    #1;
    chk("mismatch_reset", {31'd0, busy_mismatch}, 32'd0);
    reset = 1'b1;
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
